// File: rtl/tts_state_gen.sv
`default_nettype none
// ============================================================================
// Module   : tts_state_gen
// Purpose  : Generates the 4-bit TTS (trigger throttling) code from the TTC
//            link status, sticky error/out-of-sync flags and buffer occupancy,
//            using hysteresis for the READY/WARN/BUSY throttle states.
// Ports    : clk            - single clock, rising edge
//            rst_n          - synchronous active-low reset
//            ttc_ready      - TTC link ready level
//            fifo_occupancy - buffer fill in words (12-bit unsigned)
//            sync_lost      - pulse, sets sticky out-of-sync flag
//            error          - pulse, sets sticky error flag
//            error_clear    - pulse, clears both sticky flags
//            tts_state      - registered TTS code
//            state_change   - registered one-cycle pulse on tts_state change
// Options  : TTS_STATE_HOLD_EN - when defined, each throttle state must be
//            output for HOLD_CYCLES cycles before moving to another throttle
//            state.
// Revision : 1.0 - initial release
// ============================================================================
module tts_state_gen #(
    parameter logic [11:0] WARN_HI     = 12'd2048,
    parameter logic [11:0] WARN_LO     = 12'd1536,
    parameter logic [11:0] BUSY_HI     = 12'd3584,
    parameter logic [11:0] BUSY_LO     = 12'd3072,
    parameter logic [15:0] HOLD_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ttc_ready,
    input  logic [11:0] fifo_occupancy,
    input  logic        sync_lost,
    input  logic        error,
    input  logic        error_clear,
    output logic [3:0]  tts_state,
    output logic        state_change
);

    typedef enum logic [3:0] {
        ST_DISC  = 4'b0000,
        ST_READY = 4'b1000,
        ST_WARN  = 4'b0001,
        ST_BUSY  = 4'b0100,
        ST_OOS   = 4'b0010,
        ST_ERROR = 4'b1100
    } tts_state_t;

    tts_state_t r_state;
    tts_state_t w_next;
    tts_state_t w_thr;
    logic       r_err_flag;
    logic       r_oos_flag;
    logic       r_change;
    logic       w_err_next;
    logic       w_oos_next;
    logic       w_ge_warn_hi;
    logic       w_ge_busy_hi;
    logic       w_lt_warn_lo;
    logic       w_lt_busy_lo;

    // Next flag values feed the state decision directly so that a flag and
    // its ERROR/OOS code appear on the same edge; a set pulse beats a clear.
    assign w_err_next = error     | (r_err_flag & ~error_clear);
    assign w_oos_next = sync_lost | (r_oos_flag & ~error_clear);

    assign w_ge_warn_hi = (fifo_occupancy >= WARN_HI);
    assign w_ge_busy_hi = (fifo_occupancy >= BUSY_HI);
    assign w_lt_warn_lo = (fifo_occupancy <  WARN_LO);
    assign w_lt_busy_lo = (fifo_occupancy <  BUSY_LO);

`ifdef TTS_STATE_HOLD_EN
    // Number of cycles the current code has been output, counting the
    // present cycle; saturates so a long dwell never wraps back into hold.
    logic [15:0] r_hold_cnt;
    logic        w_is_thr;

    assign w_is_thr = (r_state == ST_READY) || (r_state == ST_WARN) ||
                      (r_state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= 16'd0;
        end else if (w_next != r_state) begin
            r_hold_cnt <= 16'd1;
        end else if (r_hold_cnt != 16'hFFFF) begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        w_thr  = ST_READY;
        w_next = ST_DISC;

        // Throttle hysteresis; from a non-throttle state occupancy alone
        // decides, which is the same rule as leaving READY.
        case (r_state)
            ST_WARN: begin
                if (w_ge_busy_hi)      w_thr = ST_BUSY;
                else if (w_lt_warn_lo) w_thr = ST_READY;
                else                   w_thr = ST_WARN;
            end
            ST_BUSY: begin
                if (w_lt_warn_lo)      w_thr = ST_READY;
                else if (w_lt_busy_lo) w_thr = ST_WARN;
                else                   w_thr = ST_BUSY;
            end
            default: begin
                if (w_ge_busy_hi)      w_thr = ST_BUSY;
                else if (w_ge_warn_hi) w_thr = ST_WARN;
                else                   w_thr = ST_READY;
            end
        endcase

`ifdef TTS_STATE_HOLD_EN
        // Only throttle-to-throttle moves are held back.
        if (w_is_thr && (w_thr != r_state) && (r_hold_cnt < HOLD_CYCLES)) begin
            w_thr = r_state;
        end
`endif

        if (!ttc_ready)      w_next = ST_DISC;
        else if (w_err_next) w_next = ST_ERROR;
        else if (w_oos_next) w_next = ST_OOS;
        else                 w_next = w_thr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_DISC;
            r_change   <= 1'b0;
            r_err_flag <= 1'b0;
            r_oos_flag <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_change   <= (w_next != r_state);
            r_err_flag <= w_err_next;
            r_oos_flag <= w_oos_next;
        end
    end

    assign tts_state    = r_state;
    assign state_change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_tts_state_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tts_state_gen
// Purpose  : Directed self-checking bench for tts_state_gen. Inputs change
//            1 time unit after a rising edge; outputs are sampled at the same
//            point after the following edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tts_state_gen;

    localparam logic [3:0] C_DISC  = 4'b0000;
    localparam logic [3:0] C_READY = 4'b1000;
    localparam logic [3:0] C_WARN  = 4'b0001;
    localparam logic [3:0] C_BUSY  = 4'b0100;
    localparam logic [3:0] C_OOS   = 4'b0010;
    localparam logic [3:0] C_ERROR = 4'b1100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ttc_ready;
    logic [11:0] fifo_occupancy;
    logic        sync_lost;
    logic        error;
    logic        error_clear;
    logic [3:0]  tts_state;
    logic        state_change;

    int n_checks = 0;
    int n_pass   = 0;

    tts_state_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ttc_ready      (ttc_ready),
        .fifo_occupancy (fifo_occupancy),
        .sync_lost      (sync_lost),
        .error          (error),
        .error_clear    (error_clear),
        .tts_state      (tts_state),
        .state_change   (state_change)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        sync_lost   = 1'b0;
        error       = 1'b0;
        error_clear = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic chg);
        check({tag, ".state"}, {12'd0, tts_state}, {12'd0, st});
        check({tag, ".chg"}, {15'd0, state_change}, {15'd0, chg});
    endtask

    initial begin
        rst_n          = 1'b0;
        ttc_ready      = 1'b0;
        fifo_occupancy = 12'd0;
        sync_lost      = 1'b0;
        error          = 1'b0;
        error_clear    = 1'b0;
        #1;
        tick();
        tick();
        expect_st("reset", C_DISC, 1'b0);
        ttc_ready = 1'b1;
        tick();
        expect_st("reset_ready", C_DISC, 1'b0);

        // Release: still DISC until the first edge with rst_n high.
        rst_n = 1'b1;
        #1;
        expect_st("release_pre", C_DISC, 1'b0);
        tick();
        expect_st("release", C_READY, 1'b1);
        tick();
        expect_st("release_hold", C_READY, 1'b0);

`ifndef TTS_STATE_HOLD_EN
        // Hysteresis ramp
        fifo_occupancy = 12'd2047; tick(); expect_st("occ2047", C_READY, 1'b0);
        fifo_occupancy = 12'd2048; tick(); expect_st("occ2048", C_WARN,  1'b1);
        tick();                           expect_st("occ2048b", C_WARN, 1'b0);
        fifo_occupancy = 12'd3584; tick(); expect_st("occ3584", C_BUSY,  1'b1);
        fifo_occupancy = 12'd3072; tick(); expect_st("occ3072", C_BUSY,  1'b0);
        fifo_occupancy = 12'd3071; tick(); expect_st("occ3071", C_WARN,  1'b1);
        fifo_occupancy = 12'd1536; tick(); expect_st("occ1536", C_WARN,  1'b0);
        fifo_occupancy = 12'd1535; tick(); expect_st("occ1535", C_READY, 1'b1);
        fifo_occupancy = 12'd4095; tick(); expect_st("rdy_busy", C_BUSY, 1'b1);
        fifo_occupancy = 12'd0;    tick(); expect_st("busy_rdy", C_READY, 1'b1);

        // Error set wins over a simultaneous clear
        error = 1'b1; error_clear = 1'b1;
        tick(); expect_st("err_set", C_ERROR, 1'b1);
        tick(); tick(); expect_st("err_stick", C_ERROR, 1'b0);
        fifo_occupancy = 12'd2500;
        error_clear = 1'b1;
        tick(); expect_st("err_clr", C_WARN, 1'b1);
        error = 1'b1;
        tick(); expect_st("err_again", C_ERROR, 1'b1);

        // Link loss while in ERROR: DISC for 10 cycles, ERROR returns
        ttc_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("disc_loop", {12'd0, tts_state}, {12'd0, C_DISC});
        end
        ttc_ready = 1'b1;
        tick(); expect_st("err_return", C_ERROR, 1'b1);

        // ERROR outranks OOS; clear removes both
        sync_lost = 1'b1;
        tick(); expect_st("err_over_oos", C_ERROR, 1'b0);
        error_clear = 1'b1;
        tick(); expect_st("clr_both", C_WARN, 1'b1);
        sync_lost = 1'b1;
        tick(); expect_st("oos_set", C_OOS, 1'b1);
        sync_lost = 1'b1; error_clear = 1'b1;
        tick(); expect_st("oos_wins", C_OOS, 1'b0);
        error_clear = 1'b1;
        tick(); expect_st("oos_clr", C_WARN, 1'b1);

        // Mid-operation reset
        rst_n = 1'b0;
        tick(); expect_st("reset_mid", C_DISC, 1'b1 ^ 1'b1);
        rst_n = 1'b1;
        tick(); expect_st("reenter", C_WARN, 1'b1);
`else
        begin
            int warn_cycles;
            // Let READY satisfy its own dwell first
            for (int i = 0; i < 1000; i++) tick();
            fifo_occupancy = 12'd2048;
            tick(); expect_st("hold_warn", C_WARN, 1'b1);
            warn_cycles = 1;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (tts_state == C_WARN) warn_cycles++;
            end
            fifo_occupancy = 12'd0;
            for (int i = 0; i < 2000; i++) begin
                tick();
                if (tts_state != C_WARN) break;
                warn_cycles++;
            end
            check("hold_len", warn_cycles[15:0], 16'd1000);
            expect_st("hold_ready", C_READY, 1'b1);
            tick(); tick();
            sync_lost = 1'b1;
            tick(); expect_st("hold_oos", C_OOS, 1'b1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tts_state_gen.md
TTS_STATE_GEN -- requirements
Module: tts_state_gen

Interface
Parameters:
REQ-001 SHALL define WARN_HI, default 12'd2048, occupancy at which WARN is entered.
REQ-002 SHALL define WARN_LO, default 12'd1536, occupancy below which WARN is left; WARN_LO <= WARN_HI.
REQ-003 SHALL define BUSY_HI, default 12'd3584, occupancy at which BUSY is entered; BUSY_HI > WARN_HI.
REQ-004 SHALL define BUSY_LO, default 12'd3072, occupancy below which BUSY is left; WARN_HI <= BUSY_LO <= BUSY_HI.
REQ-005 SHALL define HOLD_CYCLES, default 16'd1000, minimum dwell of a throttle state (READY/WARN/BUSY), in clk cycles.
Ports:
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port ttc_ready, input, 1, TTC link ready level.
REQ-009 SHALL have port fifo_occupancy, input, 12, data buffer fill in words, unsigned.
REQ-010 SHALL have port sync_lost, input, 1, single-cycle pulse: event/trigger sync lost.
REQ-011 SHALL have port error, input, 1, single-cycle pulse: unrecoverable error.
REQ-012 SHALL have port error_clear, input, 1, single-cycle pulse: clears sticky ERROR and OOS flags.
REQ-013 SHALL have port tts_state, output, 4, registered TTS code.
REQ-014 SHALL have port state_change, output, 1, registered one-cycle pulse when tts_state changes.

Function
REQ-015 SHALL encode states: DISC 4'b0000, READY 4'b1000, WARN 4'b0001, BUSY 4'b0100, OOS 4'b0010, ERROR 4'b1100.
REQ-016 SHALL set sticky err_flag on error and sticky oos_flag on sync_lost; both cleared by error_clear; a set input in the same cycle as error_clear wins.
REQ-017 SHALL select next state by priority: ttc_ready==0 -> DISC; err_flag -> ERROR; oos_flag -> OOS; else throttle state.
REQ-018 SHALL register tts_state; latency from any input change to tts_state is exactly 1 cycle, including setting of a sticky flag (flag set and ERROR/OOS output take effect together).
REQ-019 SHALL apply throttle hysteresis: READY->WARN at occ >= WARN_HI; WARN->BUSY at occ >= BUSY_HI; BUSY->WARN at occ < BUSY_LO; WARN->READY at occ < WARN_LO; READY->BUSY directly at occ >= BUSY_HI; BUSY->READY directly at occ < WARN_LO.
REQ-020 SHALL compare thresholds unsigned at full 12 bits; equality with _HI counts as crossing.
REQ-021 SHALL re-enter the throttle state machine from DISC/ERROR/OOS into state chosen by occupancy alone (>= BUSY_HI BUSY, >= WARN_HI WARN, else READY).
REQ-022 SHALL retain sticky flags while ttc_ready is low; on ttc_ready return, ERROR/OOS reappears if still set.
REQ-023 SHALL pulse state_change in the same cycle tts_state takes a new value; never on unchanged value.

Reset
REQ-024 SHALL, while rst_n==0 at a clk edge, set tts_state=DISC, state_change=0, err_flag=0, oos_flag=0, hold counter=0; reset mid-operation aborts any hold immediately.
REQ-025 SHALL evaluate normally from the first edge with rst_n==1.

Configuration
REQ-026 SHALL, with macro TTS_STATE_HOLD_EN defined, block throttle-to-throttle transitions until the current throttle state has been output for HOLD_CYCLES cycles; transitions to DISC/ERROR/OOS are never blocked; counter restarts on every tts_state change and saturates.
REQ-027 SHALL, without TTS_STATE_HOLD_EN, omit the hold counter and make throttle transitions take effect on the next cycle per REQ-019.

Verification
REQ-028 SHALL cover: reset release, ttc_ready=1, occ=0 -> tts_state 0000 then 1000 one cycle later, state_change pulse once.
REQ-029 SHALL cover: occ ramp 2047->2048->3584->3071->1535 (hold disabled) -> READY, WARN, BUSY, WARN, READY, each 1 cycle after change; 3072 keeps BUSY.
REQ-030 SHALL cover: error and error_clear in same cycle -> ERROR next cycle and persists; later lone error_clear -> throttle state next cycle.
REQ-031 SHALL cover: in ERROR, ttc_ready low 10 cycles then high -> DISC for 10 cycles, then ERROR again.
REQ-032 SHALL cover: TTS_STATE_HOLD_EN, HOLD_CYCLES=1000, occ 2048 for 5 cycles then 0 -> WARN held exactly 1000 cycles then READY; sync_lost during hold -> OOS next cycle.
